// File: rtl/wash_pkg.sv
// Shared definitions for the washing machine sequencer: state encoding,
// duration register addresses and small decode helpers.
package wash_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_END   = 3'd6
  } wash_state_e;

  localparam logic [1:0] CFG_WASH  = 2'd0;
  localparam logic [1:0] CFG_RINSE = 2'd1;
  localparam logic [1:0] CFG_SPIN  = 2'd2;
  localparam logic [1:0] CFG_DRAIN = 2'd3;

  // The unused code 7 behaves exactly like IDLE.
  function automatic wash_state_e norm_state(input logic [STATE_W-1:0] s);
    if (s == 3'd7) return ST_IDLE;
    return wash_state_e'(s);
  endfunction

  // Phases that own a programmable duration and end with a completion pulse.
  function automatic logic is_timed(input wash_state_e s);
    return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN) || (s == ST_DRAIN);
  endfunction

  // Duration register that belongs to a timed phase.
  function automatic logic [1:0] phase_addr(input wash_state_e s);
    case (s)
      ST_RINSE: return CFG_RINSE;
      ST_SPIN:  return CFG_SPIN;
      ST_DRAIN: return CFG_DRAIN;
      default:  return CFG_WASH;
    endcase
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Bundle between the washing machine side and the phase-timing sequencer.
interface wash_cycle_sequencer_if #(
  parameter int CNT_W = 8
);
  import wash_pkg::*;

  logic [STATE_W-1:0] state;
  logic               door_closed;
  logic               water_level;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [CNT_W-1:0]   cfg_data;
  logic               cycle_complete;
  logic               fill_timeout;
  logic [CNT_W-1:0]   remaining;
  logic               busy;

  // Machine / host side: drives state, sensors and configuration.
  modport master (
    output state, door_closed, water_level, cfg_we, cfg_addr, cfg_data,
    input  cycle_complete, fill_timeout, remaining, busy
  );

  // Sequencer side.
  modport slave (
    input  state, door_closed, water_level, cfg_we, cfg_addr, cfg_data,
    output cycle_complete, fill_timeout, remaining, busy
  );
endinterface

// File: rtl/wash_cycle_sequencer_tick_prescaler.sv
// Divides the clock into duration ticks; tick fires on the enabled cycle
// in which the counter wraps from TICK_DIV-1 back to 0.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i & (cnt_q == LAST);

  // Free-running modulo counter; clear has priority and enable low holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/wash_cycle_sequencer.sv
// Phase-timing controller: loads a duration when the washing machine enters
// a timed phase, counts it down in prescaled ticks while the door is closed
// and issues a one-cycle completion pulse. FILL is supervised by a timeout.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int TICK_DIV     = 4,
  parameter int WASH_DEF     = 5,
  parameter int RINSE_DEF    = 4,
  parameter int SPIN_DEF     = 3,
  parameter int DRAIN_DEF    = 2,
  parameter int FILL_TIMEOUT = 10
) (
  input logic             clk,
  input logic             rst_n,
  wash_cycle_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(FILL_TIMEOUT);
  localparam logic [CNT_W-1:0] DUR_DEF [4] = '{
    CNT_W'(WASH_DEF), CNT_W'(RINSE_DEF), CNT_W'(SPIN_DEF), CNT_W'(DRAIN_DEF)
  };

  logic [CNT_W-1:0] dur_q [4];
  wash_state_e      state_now, prev_q, prev_d;
  logic [CNT_W-1:0] remaining_q, remaining_d, dur_sel;
  logic             armed_q, armed_d;
  logic             cycle_complete_q, cycle_complete_d;
  logic             fill_timeout_q, fill_timeout_d;
  logic             entry, count_en, tick, done_next, fill_counting;

  assign state_now = norm_state(bus.state);
  assign entry     = (state_now != prev_q);
  assign dur_sel   = dur_q[phase_addr(state_now)];

  // FILL counts only while the tank has not yet reached its target.
  assign fill_counting = (state_now == ST_FILL) & ~bus.water_level;
  assign count_en      = bus.door_closed & ~entry & (armed_q | fill_counting);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (entry),
    .en_i    (count_en),
    .tick_o  (tick)
  );

  // True when the count is zero by the end of this cycle; using the
  // post-tick value lets the registered pulse land right as the count empties.
  assign done_next = (remaining_q == '0) | ((remaining_q == CNT_W'(1)) & tick);

  // Duration register file; a write in the entry cycle is seen only at the
  // following entry because the load uses the current register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dur_q[i] <= DUR_DEF[i];
    end else if (bus.cfg_we) begin
      dur_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Next-state logic for the phase tracker, countdown, arm and fault flag.
  always_comb begin
    prev_d           = prev_q;
    remaining_d      = remaining_q;
    armed_d          = armed_q;
    fill_timeout_d   = fill_timeout_q;
    cycle_complete_d = 1'b0;
    if (entry) begin
      // A phase change always wins over a completion due in the same cycle.
      prev_d      = state_now;
      armed_d     = 1'b0;
      remaining_d = '0;
      if (is_timed(state_now)) begin
        remaining_d = dur_sel;
        armed_d     = 1'b1;
      end else if (state_now == ST_FILL) begin
        remaining_d = FILL_LOAD;
      end
      if (state_now == ST_IDLE) fill_timeout_d = 1'b0;
    end else begin
      if (tick && (remaining_q != '0)) remaining_d = remaining_q - 1'b1;
      if (armed_q && bus.door_closed && done_next) begin
        cycle_complete_d = 1'b1;
        armed_d          = 1'b0;
      end
      if (fill_counting && bus.door_closed && done_next) fill_timeout_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q           <= ST_IDLE;
      remaining_q      <= '0;
      armed_q          <= 1'b0;
      fill_timeout_q   <= 1'b0;
      cycle_complete_q <= 1'b0;
    end else begin
      prev_q           <= prev_d;
      remaining_q      <= remaining_d;
      armed_q          <= armed_d;
      fill_timeout_q   <= fill_timeout_d;
      cycle_complete_q <= cycle_complete_d;
    end
  end

  // armed is only ever set in a timed phase and is dropped on every entry,
  // so it already equals "armed and in a timed phase".
  assign bus.cycle_complete = cycle_complete_q;
  assign bus.fill_timeout   = fill_timeout_q;
  assign bus.remaining      = remaining_q;
  assign bus.busy           = armed_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Self-checking bench for wash_cycle_sequencer with TICK_DIV=4.
module tb_wash_cycle_sequencer;
  import wash_pkg::*;

  localparam int CNT_W    = 8;
  localparam int TDIV     = 4;
  localparam int FILL_TO  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wash_cycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  wash_cycle_sequencer #(
    .CNT_W(CNT_W), .TICK_DIV(TDIV), .WASH_DEF(5), .RINSE_DEF(4),
    .SPIN_DEF(3), .DRAIN_DEF(2), .FILL_TIMEOUT(FILL_TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int dur_m [4] = '{5, 4, 3, 2};  // bench's own copy of the duration registers
  bit ft_m      = 1'b0;           // expected sticky fill fault

  // Runs one phase from its entry cycle (cycle 0). Model: the phase ends once
  // need = max(D*TDIV,1) counting cycles (door closed, k>=1) have elapsed; the
  // pulse appears the cycle after the last one; remaining = D - counted/TDIV.
  // len>0 runs exactly len cycles; len<=0 runs until 2 cycles past the pulse.
  task automatic run_phase(input int st, input int len, input int door_mode,
                           input int open_start, input int open_len,
                           input int water_rise, input int wr_cycle,
                           input int wr_addr, input int wr_data,
                           output int pulse_at);
    int d, need, cnt, trig, exp_rem;
    bit timed, fill, done, door, water, exp_cc, exp_busy, finished;
    timed = (st >= 2 && st <= 5);
    fill  = (st == 1);
    d     = timed ? dur_m[st-2] : (fill ? FILL_TO : 0);
    need  = (d == 0) ? 1 : d * TDIV;
    cnt = 0; trig = -1; done = 0; pulse_at = -1; finished = 0;
    if (st == 0 || st == 7) ft_m = 1'b0;
    bus.state = 3'(st);
    for (int k = 0; k < 400; k++) begin
      if (door_mode == 0)      door = 1'b1;
      else if (door_mode == 1) door = !(k >= open_start && k < open_start + open_len);
      else                     door = ($urandom_range(0, 3) != 0);
      water = (water_rise >= 0) && (k >= water_rise);
      bus.door_closed = door;
      bus.water_level = water;
      bus.cfg_we      = (k == wr_cycle);
      bus.cfg_addr    = 2'(wr_addr);
      bus.cfg_data    = CNT_W'(wr_data);
      @(negedge clk);
      if (bus.cycle_complete === 1'b1 && k >= 1 && pulse_at < 0) pulse_at = k;
      if (k >= 1) begin
        exp_cc   = timed && done && (k == trig + 1);
        exp_busy = timed && !done;
        exp_rem  = (timed || fill) ? d - cnt / TDIV : 0;
        if (exp_rem < 0) exp_rem = 0;
        checks += 4;
        if (bus.cycle_complete !== exp_cc) begin
          failures++;
          $display("FAIL cycle_complete st=%0d cyc=%0d got=%b exp=%b", st, k, bus.cycle_complete, exp_cc);
        end
        if (bus.busy !== exp_busy) begin
          failures++;
          $display("FAIL busy st=%0d cyc=%0d got=%b exp=%b", st, k, bus.busy, exp_busy);
        end
        if (bus.remaining !== CNT_W'(exp_rem)) begin
          failures++;
          $display("FAIL remaining st=%0d cyc=%0d got=%0d exp=%0d", st, k, bus.remaining, exp_rem);
        end
        if (bus.fill_timeout !== ft_m) begin
          failures++;
          $display("FAIL fill_timeout st=%0d cyc=%0d got=%b exp=%b", st, k, bus.fill_timeout, ft_m);
        end
      end
      if (k == wr_cycle) dur_m[wr_addr] = wr_data;
      if (k >= 1 && door && ((timed && !done) || (fill && !water))) begin
        cnt++;
        if (timed && cnt == need) begin done = 1'b1; trig = k; end
        if (fill && cnt >= need) ft_m = 1'b1;
      end
      @(posedge clk); #1;
      if (len > 0 && k + 1 >= len) begin finished = 1; break; end
      if (len <= 0 && done && k >= trig + 2) begin finished = 1; break; end
    end
    bus.cfg_we = 1'b0;
    if (!finished) begin
      checks++; failures++;
      $display("FAIL phase_budget st=%0d got=no_completion exp=completion", st);
    end
    $display("phase st=%0d dur=%0d pulse_at=%0d", st, d, pulse_at);
  endtask

  task automatic go_idle(input int st);
    int p;
    run_phase(st, 3, 0, 0, 0, -1, -1, 0, 0, p);
  endtask

  task automatic cfg_write(input int addr, input int data);
    int p;
    run_phase(0, 2, 0, 0, 0, -1, 0, addr, data, p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.state = 3'd0; bus.door_closed = 1'b1; bus.water_level = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.cycle_complete !== 1'b0) begin failures++; $display("FAIL reset_cc got=%b exp=0", bus.cycle_complete); end
    if (bus.fill_timeout !== 1'b0)   begin failures++; $display("FAIL reset_ft got=%b exp=0", bus.fill_timeout); end
    if (bus.remaining !== '0)        begin failures++; $display("FAIL reset_rem got=%0d exp=0", bus.remaining); end
    if (bus.busy !== 1'b0)           begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    go_idle(0);
  endtask

  task automatic test_wash_default();
    int p;
    run_phase(2, -1, 0, 0, 0, -1, -1, 0, 0, p);
    checks++;
    if (p !== 21) begin failures++; $display("FAIL wash_default_pulse got=%0d exp=21", p); end
    go_idle(0);
  endtask

  task automatic test_reprogram_rinse();
    int p;
    cfg_write(1, 1);
    run_phase(3, -1, 0, 0, 0, -1, 2, 1, 9, p);
    checks++;
    if (p !== 5) begin failures++; $display("FAIL rinse_short_pulse got=%0d exp=5", p); end
    go_idle(0);
    run_phase(3, -1, 0, 0, 0, -1, -1, 0, 0, p);
    checks++;
    if (p !== 37) begin failures++; $display("FAIL rinse_long_pulse got=%0d exp=37", p); end
    go_idle(0);
    cfg_write(1, 4);
  endtask

  task automatic test_door_pause();
    int p;
    run_phase(4, -1, 1, 5, 7, -1, -1, 0, 0, p);
    checks++;
    if (p !== 20) begin failures++; $display("FAIL door_pause_pulse got=%0d exp=20", p); end
    go_idle(0);
  endtask

  task automatic test_fill_timeout();
    int p;
    run_phase(1, 46, 0, 0, 0, -1, -1, 0, 0, p);
    checks += 2;
    if (bus.fill_timeout !== 1'b1) begin failures++; $display("FAIL fill_fault_set got=%b exp=1", bus.fill_timeout); end
    if (p !== -1) begin failures++; $display("FAIL fill_no_pulse got=%0d exp=-1", p); end
    go_idle(0);
    checks++;
    if (bus.fill_timeout !== 1'b0) begin failures++; $display("FAIL fill_fault_clear got=%b exp=0", bus.fill_timeout); end
    run_phase(1, 60, 0, 0, 0, 8, -1, 0, 0, p);
    @(negedge clk);
    checks += 2;
    if (bus.fill_timeout !== 1'b0) begin failures++; $display("FAIL fill_water_ok got=%b exp=0", bus.fill_timeout); end
    if (bus.remaining !== 8'd9) begin failures++; $display("FAIL fill_frozen_rem got=%0d exp=9", bus.remaining); end
    @(posedge clk); #1;
    go_idle(0);
  endtask

  task automatic test_phase_override();
    int p;
    run_phase(2, 20, 0, 0, 0, -1, -1, 0, 0, p);
    checks++;
    if (p !== -1) begin failures++; $display("FAIL override_wash_pulse got=%0d exp=-1", p); end
    run_phase(3, -1, 0, 0, 0, -1, -1, 0, 0, p);
    checks++;
    if (p !== 17) begin failures++; $display("FAIL override_rinse_pulse got=%0d exp=17", p); end
    go_idle(0);
  endtask

  task automatic test_reset_mid_drain();
    int p;
    cfg_write(0, 2);
    run_phase(5, 5, 0, 0, 0, -1, -1, 0, 0, p);
    #1 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.cycle_complete !== 1'b0) begin failures++; $display("FAIL rst_drain_cc got=%b exp=0", bus.cycle_complete); end
    if (bus.fill_timeout !== 1'b0)   begin failures++; $display("FAIL rst_drain_ft got=%b exp=0", bus.fill_timeout); end
    if (bus.remaining !== '0)        begin failures++; $display("FAIL rst_drain_rem got=%0d exp=0", bus.remaining); end
    if (bus.busy !== 1'b0)           begin failures++; $display("FAIL rst_drain_busy got=%b exp=0", bus.busy); end
    dur_m = '{5, 4, 3, 2};
    ft_m  = 1'b0;
    bus.state = 3'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    go_idle(0);
    run_phase(2, -1, 0, 0, 0, -1, -1, 0, 0, p);
    checks++;
    if (p !== 21) begin failures++; $display("FAIL rst_defaults_wash got=%0d exp=21", p); end
    go_idle(0);
  endtask

  task automatic test_random();
    int p, st, wc, wa, wd;
    int rest [3] = '{0, 6, 7};
    for (int it = 0; it < 14; it++) begin
      cfg_write($urandom_range(0, 3), $urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) begin
        run_phase(1, 50, 2, 0, 0, $urandom_range(0, 60), -1, 0, 0, p);
      end else begin
        st = $urandom_range(2, 5);
        wc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
        wa = ($urandom_range(0, 1) == 1) ? st - 2 : $urandom_range(0, 3);
        wd = $urandom_range(0, 6);
        run_phase(st, -1, $urandom_range(0, 1) * 2, 0, 0, -1, wc, wa, wd, p);
      end
      go_idle(rest[$urandom_range(0, 2)]);
    end
    go_idle(0);
  endtask

  initial begin
    test_reset();
    test_wash_default();
    test_reprogram_rinse();
    test_door_pause();
    test_fill_timeout();
    test_phase_override();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
